prefix_carry_pipe: RTL and testbench

Pipelined parallel-prefix (Kogge-Stone) carry generator for the MAC accumulator adder.
- Accepts operand pairs plus carry-in through a valid/ready handshake.
- Delivers per-bit propagate `p_out` and per-bit carry `c_out` after three register stages.
- These are the producer end of the triangle sum cells: sum bit i = `p_out[i]` XOR `c_out[i-1]`, where `c_out[-1]` = `cin_out`.
- Sustains one operation per cycle under back-pressure.

---
 rtl/mac_pkg.sv | 17 +
 rtl/prefix_dot.sv | 15 +
 rtl/prefix_carry_pipe.sv | 188 ++++++++++++++++++
 tb/tb_prefix_carry_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC accumulator datapath.
// Prefix-level count and stage split for the carry pipeline.
package mac_pkg;

  localparam int MAC_WIDTH = 16;

  function automatic int PREFIX_LEVELS(input int w);
    return $clog2(w);
  endfunction

  function automatic int prefix_split(input int w);
    return (PREFIX_LEVELS(w) + 1) / 2;
  endfunction

  localparam int PREFIX_SPLIT = prefix_split(MAC_WIDTH);

endpackage

// File: rtl/prefix_dot.sv
// Kogge-Stone black cell: (G,P)i o (G,P)j.
// Purely combinational.
module prefix_dot (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  assign go = gi | (pi & gj);
  assign po = pi & pj;

endmodule

// File: rtl/prefix_carry_pipe.sv
// Three-stage Kogge-Stone carry generator.
// Valid/ready pipeline, one op per cycle.
module prefix_carry_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] c_out,
  output logic             cin_out
);

  localparam int L     = PREFIX_LEVELS(WIDTH);
  localparam int SPLIT = prefix_split(WIDTH);
  localparam int N2    = L - SPLIT;

  logic             v0_q, v1_q, v2_q;
  logic             v0_d, v1_d, v2_d;
  logic             ld0, ld1, ld2;

  logic [WIDTH-1:0] p0_q, g0_q;
  logic [WIDTH-1:0] p0_d, g0_d;
  logic             cin0_q, cin0_d;

  logic [WIDTH-1:0] p1_q, g1_q, gp1_q;
  logic [WIDTH-1:0] p1_d, g1_d, gp1_d;
  logic             cin1_q, cin1_d;

  logic [WIDTH-1:0] p2_q, c_q;
  logic [WIDTH-1:0] p2_d, c_d;
  logic             cin2_q, cin2_d;

  logic [WIDTH-1:0] s1_g, s1_p;
  logic [WIDTH-1:0] s2_g;
  logic             unused_pg;

  // Stage 1 prefix levels 1..SPLIT
  for (genvar k = 0; k < SPLIT; k++) begin : g_s1
    localparam int D = 1 << k;
    logic [WIDTH-1:0] gi, pi, go, po;
    if (k == 0) begin : g_src
      assign gi = g0_q;
      assign pi = p0_q;
    end else begin : g_src
      assign gi = g_s1[k-1].go;
      assign pi = g_s1[k-1].po;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end else begin : g_cell
        prefix_dot u_dot (
          .gi(gi[i]),
          .pi(pi[i]),
          .gj(gi[i-D]),
          .pj(pi[i-D]),
          .go(go[i]),
          .po(po[i])
        );
      end
    end
  end

  assign s1_g = g_s1[SPLIT-1].go;
  assign s1_p = g_s1[SPLIT-1].po;

  // Stage 2 prefix levels SPLIT+1..L
  for (genvar k = 0; k < N2; k++) begin : g_s2
    localparam int D = 1 << (SPLIT + k);
    logic [WIDTH-1:0] gi, pi, go, po;
    if (k == 0) begin : g_src
      assign gi = g1_q;
      assign pi = gp1_q;
    end else begin : g_src
      assign gi = g_s2[k-1].go;
      assign pi = g_s2[k-1].po;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end else begin : g_cell
        prefix_dot u_dot (
          .gi(gi[i]),
          .pi(pi[i]),
          .gj(gi[i-D]),
          .pj(pi[i-D]),
          .go(go[i]),
          .po(po[i])
        );
      end
    end
  end

  assign s2_g      = g_s2[N2-1].go;
  assign unused_pg = ^g_s2[N2-1].po;

  // Load enables ripple back from the output handshake
  always_comb begin
    ld2  = !v2_q || out_ready;
    ld1  = !v1_q || ld2;
    ld0  = !v0_q || ld1;
    v0_d = ld0 ? in_valid : v0_q;
    v1_d = ld1 ? v0_q : v1_q;
    v2_d = ld2 ? v1_q : v2_q;
  end

  // Datapath next state; registers move only on a real load
  always_comb begin
    p0_d   = p0_q;
    g0_d   = g0_q;
    cin0_d = cin0_q;
    p1_d   = p1_q;
    g1_d   = g1_q;
    gp1_d  = gp1_q;
    cin1_d = cin1_q;
    p2_d   = p2_q;
    c_d    = c_q;
    cin2_d = cin2_q;
    if (ld0 && in_valid) begin
      p0_d    = a ^ b;
      g0_d    = a & b;
      g0_d[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
      cin0_d  = cin;
    end
    if (ld1 && v0_q) begin
      p1_d   = p0_q;
      g1_d   = s1_g;
      gp1_d  = s1_p;
      cin1_d = cin0_q;
    end
    if (ld2 && v1_q) begin
      p2_d   = p1_q;
      c_d    = s2_g;
      cin2_d = cin1_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      p0_q   <= '0;
      g0_q   <= '0;
      cin0_q <= 1'b0;
      p1_q   <= '0;
      g1_q   <= '0;
      gp1_q  <= '0;
      cin1_q <= 1'b0;
      p2_q   <= '0;
      c_q    <= '0;
      cin2_q <= 1'b0;
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      p0_q   <= p0_d;
      g0_q   <= g0_d;
      cin0_q <= cin0_d;
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      gp1_q  <= gp1_d;
      cin1_q <= cin1_d;
      p2_q   <= p2_d;
      c_q    <= c_d;
      cin2_q <= cin2_d;
    end
  end

  assign in_ready  = ld0;
  assign out_valid = v2_q;
  assign p_out     = p2_q;
  assign c_out     = c_q;
  assign cin_out   = cin2_q;

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Bench for prefix_carry_pipe: vector table,
// back-pressure, random stream and reset cases.
module tb_prefix_carry_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid, out_ready;
  logic [15:0] p_out, c_out;
  logic        cin_out;

  prefix_carry_pipe #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p_out(p_out),
    .c_out(c_out),
    .cin_out(cin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] ep;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] ep;
    logic [15:0] ec;
    int          cyc;
    bit          lat;
  } item_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  item_t q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [15:0] ia,
                               input logic [15:0] ib,
                               input logic ic,
                               input bit lat);
    item_t t;
    logic  cy;
    cy    = ic;
    t.a   = ia;
    t.b   = ib;
    t.cin = ic;
    t.ep  = ia ^ ib;
    for (int i = 0; i < 16; i++) begin
      t.ec[i] = (ia[i] & ib[i]) | ((ia[i] ^ ib[i]) & cy);
      cy = t.ec[i];
    end
    t.cyc = 0;
    t.lat = lat;
    return t;
  endfunction

  task automatic pop_check();
    item_t       e;
    logic [16:0] rs, es;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious: got out p=0x%0h c=0x%0h want none",
               p_out, c_out);
    end else begin
      e  = q.pop_front();
      chk("p_out", 32'(p_out), 32'(e.ep));
      chk("c_out", 32'(c_out), 32'(e.ec));
      chk("cin_out", 32'(cin_out), 32'(e.cin));
      rs = {c_out[15], p_out ^ {c_out[14:0], cin_out}};
      es = {1'b0, e.a} + {1'b0, e.b} + {16'b0, e.cin};
      chk("sum", 32'(rs), 32'(es));
      if (e.lat) chk("latency", cyc - e.cyc, 3);
    end
  endtask

  task automatic step(input logic iv,
                      input item_t it,
                      input logic ordy,
                      output logic acc);
    item_t t;
    in_valid  = iv;
    a         = it.a;
    b         = it.b;
    cin       = it.cin;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (out_valid && out_ready) pop_check();
    if (acc) begin
      t     = it;
      t.cyc = cyc;
      q.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    logic  acc;
    item_t z;
    int    n;
    z = mk(16'h0, 16'h0, 1'b0, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      step(1'b0, z, 1'b1, acc);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               q.size());
      q.delete();
    end
  endtask

  vec_t  tbl[9];
  item_t bp[5];
  item_t it, z;
  logic  acc;
  int    idx, cnt, pushed, guard;
  logic [15:0] hp, hc;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 16'hFFFF};
    tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5115, 16'h0221};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
    tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 16'h0001};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000};
    tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h00FE, 16'h00FF};
    tbl[7] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 16'h0000};
    tbl[8] = '{16'h5555, 16'hAAAA, 1'b1, 16'hFFFF, 16'hFFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    z = mk(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_p_out", 32'(p_out), 0);
    chk("rst_c_out", 32'(c_out), 0);
    chk("rst_cin_out", 32'(cin_out), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      it     = mk(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
      it.ep  = tbl[i].ep;
      it.ec  = tbl[i].ec;
      step(1'b1, it, 1'b1, acc);
      chk("tbl_accept", 32'(acc), 1);
      drain();
    end

    bp[0] = mk(16'h0101, 16'h0202, 1'b0, 1'b0);
    bp[1] = mk(16'hF00F, 16'h0FF1, 1'b1, 1'b0);
    bp[2] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    bp[3] = mk(16'hABCD, 16'h1234, 1'b1, 1'b0);
    bp[4] = mk(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    idx = 0;
    hp  = '0;
    hc  = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bp[idx], 1'b0, acc);
      if (acc) idx++;
      if (i == 3) begin
        hp = p_out;
        hc = c_out;
      end
    end
    chk("bp_accepted", idx, 3);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_hold_p", 32'(p_out), 32'(hp));
    chk("bp_hold_c", 32'(c_out), 32'(hc));
    cnt = 0;
    while (q.size() != 0 && cnt < 20) begin
      step(idx < 5, bp[idx < 5 ? idx : 4], 1'b1, acc);
      if (acc) idx++;
      cnt++;
    end
    chk("bp_all_pushed", idx, 5);
    chk("bp_cycles", cnt, 5);
    drain();

    pushed = 0;
    guard  = 0;
    while (pushed < 10000 && guard < 60000) begin
      it = mk(16'($urandom), 16'($urandom),
              1'($urandom), 1'b0);
      step($urandom_range(0, 3) != 0, it, guard[0], acc);
      if (acc) pushed++;
      guard++;
    end
    chk("rand_pushed", pushed, 10000);
    drain();

    idx   = 0;
    guard = 0;
    while (idx < 3 && guard < 10) begin
      step(1'b1, bp[idx], 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    chk("rst_fill", idx, 3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 0);
    chk("rstmid_in_ready", 32'(in_ready), 1);
    chk("rstmid_p_out", 32'(p_out), 0);
    chk("rstmid_c_out", 32'(c_out), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, z, 1'b1, acc);
    chk("rstmid_no_stale", 32'(out_valid), 0);
    it = mk(16'h0001, 16'h0001, 1'b0, 1'b1);
    it.ep = 16'h0000;
    it.ec = 16'h0001;
    step(1'b1, it, 1'b1, acc);
    chk("rstmid_accept", 32'(acc), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
